// File: rtl/music_sequencer_pkg.sv
// music_pkg: shared constants for the music sequencer.
//   - note codes understood by the tone generator
//   - note/space durations in ticks
//   - default tick divider width
//   - the fixed 25-entry melody ROM ({is_long, code} per entry)
//   - FSM state encodings (ST_PAUSED is only reachable with MUSIC_SEQ_PAUSE_EN)
package music_pkg;

  typedef logic [2:0] note_code_t;

  localparam note_code_t NOTE_GSHARP = 3'd0;
  localparam note_code_t NOTE_FSHARP = 3'd1;
  localparam note_code_t NOTE_DSHARP = 3'd2;
  localparam note_code_t NOTE_D      = 3'd3;
  localparam note_code_t NOTE_CSHARP = 3'd4;
  localparam note_code_t NOTE_B      = 3'd5;

  localparam int SHORT_TICKS        = 3;
  localparam int LONG_TICKS         = 7;
  localparam int SPACE_TICKS        = 1;
  localparam int DEFAULT_TICK_WIDTH = 5468;
  localparam int ROM_LEN            = 25;

  typedef struct packed {
    logic       is_long;
    note_code_t code;
  } melody_entry_t;

  localparam melody_entry_t MELODY_ROM [ROM_LEN] = '{
    {1'b1, NOTE_FSHARP}, {1'b1, NOTE_GSHARP}, {1'b0, NOTE_D},      {1'b1, NOTE_DSHARP},
    {1'b0, NOTE_B},      {1'b0, NOTE_D},      {1'b0, NOTE_CSHARP}, {1'b1, NOTE_B},
    {1'b1, NOTE_B},      {1'b1, NOTE_CSHARP}, {1'b1, NOTE_D},      {1'b0, NOTE_D},
    {1'b0, NOTE_CSHARP}, {1'b0, NOTE_B},      {1'b0, NOTE_CSHARP}, {1'b0, NOTE_DSHARP},
    {1'b0, NOTE_FSHARP}, {1'b0, NOTE_GSHARP}, {1'b0, NOTE_DSHARP}, {1'b0, NOTE_FSHARP},
    {1'b0, NOTE_CSHARP}, {1'b0, NOTE_D},      {1'b0, NOTE_B},      {1'b0, NOTE_CSHARP},
    {1'b0, NOTE_B}
  };

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OFFER  = 3'd1;
  localparam logic [2:0] ST_NOTE   = 3'd2;
  localparam logic [2:0] ST_SPACE  = 3'd3;
  localparam logic [2:0] ST_PAUSED = 3'd4;

  // Index of the last tick of a note, as compared against the tick counter.
  function automatic logic [2:0] note_last_tick(input melody_entry_t e);
    return e.is_long ? 3'(LONG_TICKS - 1) : 3'(SHORT_TICKS - 1);
  endfunction

endpackage

// File: rtl/music_sequencer_if.sv
// music_sequencer_if: link between the sequencer and the tone generator.
//   note_code  - note index offered to the tone generator
//   note_valid - note_code is being offered
//   note_ready - tone generator accepts note_code
//   note_gate  - tone is audible (PWM enable)
// Modports: master = sequencer, slave = tone generator.
interface music_sequencer_if;
  import music_pkg::*;

  note_code_t note_code;
  logic       note_valid;
  logic       note_ready;
  logic       note_gate;

  modport master (output note_code, output note_valid, output note_gate, input note_ready);
  modport slave  (input note_code, input note_valid, input note_gate, output note_ready);

endinterface

// File: rtl/music_sequencer_tick_div.sv
// music_tick_div: counts sample strobes and emits one tick every TICK_WIDTH
// strobes.
//   clk, rst   - clock, asynchronous active-high reset
//   clr        - synchronous clear of the strobe count
//   en         - count enable; strobes outside en are ignored
//   sample_stb - sample-rate strobe being counted
//   tick       - high in the cycle whose strobe completes a tick
module music_tick_div
  import music_pkg::*;
#(
  parameter int TICK_WIDTH = DEFAULT_TICK_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sample_stb,
  output logic tick
);

  localparam int CW = (TICK_WIDTH > 1) ? $clog2(TICK_WIDTH) : 1;

  logic [CW-1:0] cnt;
  logic          at_top;

  assign at_top = (cnt == CW'(TICK_WIDTH - 1));
  // Combinational so the sequencer can act on the same edge that wraps the count.
  assign tick   = en && sample_stb && at_top;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && sample_stb) begin
      cnt <= at_top ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// music_sequencer: plays the fixed melody ROM as a loop of gated notes.
// Each entry is offered to the tone generator (valid/ready), then gated for
// 3 or 7 ticks, followed by a 1-tick silent space.
//   clk, rst      - clock, asynchronous active-high reset
//   sample_stb    - one-cycle pulse per sample period
//   play / stop   - start from IDLE / abort to IDLE (stop has priority)
//   pause         - pause request, only honoured with MUSIC_SEQ_PAUSE_EN
//   tone          - music_sequencer_if.master (note_code/valid/ready/gate)
//   melody_pos    - current melody index
//   loop_done     - one-cycle pulse when melody_pos wraps to 0
//   busy          - high in every state except IDLE
// Build option: define MUSIC_SEQ_PAUSE_EN to enable the PAUSED state.
module music_sequencer
  import music_pkg::*;
#(
  parameter int TICK_WIDTH = DEFAULT_TICK_WIDTH,
  parameter int MELODY_LEN = ROM_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_stb,
  input  logic                     play,
  input  logic                     stop,
  input  logic                     pause,
  music_sequencer_if.master        tone,
  output logic [4:0]               melody_pos,
  output logic                     loop_done,
  output logic                     busy
);

  logic [2:0]    state, state_n;
  logic [2:0]    tick_cnt, tick_cnt_n;
  logic [4:0]    pos_n;
  logic          loop_n;
  logic          tick, div_clr, div_en, hold;
  melody_entry_t cur_entry, nxt_entry;

`ifdef MUSIC_SEQ_PAUSE_EN
  logic [2:0] resume_state;
  assign hold = pause;
`else
  logic pause_unused;
  assign pause_unused = pause;
  assign hold         = 1'b0;
`endif

  assign cur_entry = MELODY_ROM[melody_pos];
  assign nxt_entry = MELODY_ROM[pos_n];

  // A pause request freezes the divider in the same cycle it stops the FSM,
  // so no strobe is lost or double-counted across a pause.
  assign div_en  = ((state == ST_NOTE) || (state == ST_SPACE)) && !hold;
  assign div_clr = stop || ((state == ST_OFFER) && tone.note_ready);

  music_tick_div #(.TICK_WIDTH(TICK_WIDTH)) u_tick_div (
    .clk        (clk),
    .rst        (rst),
    .clr        (div_clr),
    .en         (div_en),
    .sample_stb (sample_stb),
    .tick       (tick)
  );

  // Next-state logic; stop overrides everything, including play and pause.
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    pos_n      = melody_pos;
    loop_n     = 1'b0;
    if (stop) begin
      state_n    = ST_IDLE;
      tick_cnt_n = '0;
      pos_n      = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (play) begin
            state_n    = ST_OFFER;
            tick_cnt_n = '0;
            pos_n      = '0;
          end
        end
        ST_OFFER: begin
          if (tone.note_ready) begin
            state_n    = ST_NOTE;
            tick_cnt_n = '0;
          end
        end
        ST_NOTE: begin
          if (tick) begin
            if (tick_cnt == note_last_tick(cur_entry)) begin
              state_n    = ST_SPACE;
              tick_cnt_n = '0;
            end else begin
              tick_cnt_n = tick_cnt + 3'd1;
            end
          end
`ifdef MUSIC_SEQ_PAUSE_EN
          if (hold) state_n = ST_PAUSED;
`endif
        end
        ST_SPACE: begin
          if (tick) begin
            if (tick_cnt == 3'(SPACE_TICKS - 1)) begin
              state_n    = ST_OFFER;
              tick_cnt_n = '0;
              if (melody_pos == 5'(MELODY_LEN - 1)) begin
                pos_n  = '0;
                loop_n = 1'b1;
              end else begin
                pos_n = melody_pos + 5'd1;
              end
            end else begin
              tick_cnt_n = tick_cnt + 3'd1;
            end
          end
`ifdef MUSIC_SEQ_PAUSE_EN
          if (hold) state_n = ST_PAUSED;
`endif
        end
`ifdef MUSIC_SEQ_PAUSE_EN
        ST_PAUSED: begin
          if (!pause) state_n = resume_state;
        end
`endif
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      tick_cnt        <= '0;
      melody_pos      <= '0;
      loop_done       <= 1'b0;
      busy            <= 1'b0;
      tone.note_gate  <= 1'b0;
      tone.note_valid <= 1'b0;
      tone.note_code  <= '0;
    end else begin
      state           <= state_n;
      tick_cnt        <= tick_cnt_n;
      melody_pos      <= pos_n;
      loop_done       <= loop_n;
      busy            <= (state_n != ST_IDLE);
      tone.note_gate  <= (state_n == ST_NOTE);
      tone.note_valid <= (state_n == ST_OFFER);
      tone.note_code  <= (state_n == ST_IDLE) ? '0 : nxt_entry.code;
    end
  end

`ifdef MUSIC_SEQ_PAUSE_EN
  // Remember which state to return to when the pause is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resume_state <= ST_IDLE;
    end else if ((state_n == ST_PAUSED) && (state != ST_PAUSED)) begin
      resume_state <= state;
    end
  end
`endif

endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: scoreboard bench for music_sequencer with TICK_WIDTH=4
// and a sample strobe every second cycle. Expected notes (position, code,
// gated strobe count) are queued when a run is started and popped on each
// note handshake. Honours MUSIC_SEQ_PAUSE_EN for the pause scenario.
module tb_music_sequencer;

  localparam int TW            = 4;
  localparam int LEN           = 25;
  localparam int SPACE_STROBES = TW;
`ifdef MUSIC_SEQ_PAUSE_EN
  localparam int PAUSE_GATE = 0;
`else
  localparam int PAUSE_GATE = 1;
`endif

  // Melody as written out in the requirements: G#=0 F#=1 D#=2 D=3 C#=4 B=5.
  localparam int ROM_CODE [LEN] = '{1,0,3,2,5,3,4,5,5,4,3,3,4,5,4,2,1,0,2,1,4,3,5,4,5};
  localparam int ROM_LONG [LEN] = '{1,1,0,1,0,0,0,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0};

  typedef struct {
    int pos;
    int code;
    int len;
  } exp_t;

  logic       clk, rst, sample_stb, play, stop, pause;
  logic [4:0] melody_pos;
  logic       loop_done, busy;

  music_sequencer_if tone_if ();

  music_sequencer #(.TICK_WIDTH(TW), .MELODY_LEN(LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_stb (sample_stb),
    .play       (play),
    .stop       (stop),
    .pause      (pause),
    .tone       (tone_if),
    .melody_pos (melody_pos),
    .loop_done  (loop_done),
    .busy       (busy)
  );

  int   check_cnt = 0;
  int   pass_cnt  = 0;
  exp_t exp_q[$];
  exp_t e;
  int   gate_cnt = 0, space_cnt = 0, pend_len = 0, loop_cnt = 0, prev_pos = 0;
  bit   pending = 0, prev_valid = 0, pause_d = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    sample_stb = 0;
    forever begin
      @(posedge clk);
      #1 sample_stb = ~sample_stb;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_cnt++;
    if (observed == expected) pass_cnt++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic pushRun(input int first, input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.pos  = (first + i) % LEN;
      x.code = ROM_CODE[x.pos];
      x.len  = (ROM_LONG[x.pos] != 0 ? 7 : 3) * TW;
      exp_q.push_back(x);
    end
  endtask

  // Drives play/stop for exactly one clock edge.
  task automatic applyStimulus(input logic p, input logic s);
    @(posedge clk);
    #2 play = p; stop = s;
    @(posedge clk);
    #2 play = 0; stop = 0;
  endtask

  task automatic waitQueue(input int target, input int budget, input string tag);
    int n = 0;
    while (exp_q.size() > target && n < budget) begin
      @(negedge clk); #1; n++;
    end
    checkOutput(tag, exp_q.size(), target);
  endtask

  task automatic waitGateHigh(input int budget);
    int n = 0;
    while (!tone_if.note_gate && n < budget) begin
      @(negedge clk); #1; n++;
    end
    checkOutput("wait_gate", tone_if.note_gate, 1);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"},  busy, 0);
    checkOutput({tag, "_gate"},  tone_if.note_gate, 0);
    checkOutput({tag, "_valid"}, tone_if.note_valid, 0);
    checkOutput({tag, "_pos"},   melody_pos, 0);
  endtask

  // Scoreboard monitor: pops one expected note per handshake and checks the
  // previous note's gated/space strobe counts when the next offer begins.
  always @(negedge clk) begin
    if (rst || !busy) begin
      pending   = 0;
      gate_cnt  = 0;
      space_cnt = 0;
    end else begin
      if (tone_if.note_valid && !prev_valid && pending) begin
        checkOutput("gate_len", gate_cnt, pend_len);
        checkOutput("space_len", space_cnt, SPACE_STROBES);
        pending = 0;
      end
      if (tone_if.note_valid && tone_if.note_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_note", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("note_code", tone_if.note_code, e.code);
          checkOutput("melody_pos", melody_pos, e.pos);
          pend_len  = e.len;
          pending   = 1;
          gate_cnt  = 0;
          space_cnt = 0;
        end
      end
      if (sample_stb && tone_if.note_gate) gate_cnt++;
      if (sample_stb && !tone_if.note_gate && !tone_if.note_valid && !pause_d) space_cnt++;
      checkOutput("gate_valid_excl", tone_if.note_gate & tone_if.note_valid, 0);
      if (loop_done) begin
        loop_cnt++;
        checkOutput("loop_pos", melody_pos, 0);
        checkOutput("loop_prev_pos", prev_pos, LEN - 1);
      end
    end
    prev_valid = tone_if.note_valid;
    prev_pos   = melody_pos;
    pause_d    = pause;
  end

  initial begin
    rst = 1; play = 0; stop = 0; pause = 0;
    tone_if.note_ready = 0;

    // Reset state
    repeat (3) @(negedge clk);
    checkIdle("rst");
    checkOutput("rst_code", tone_if.note_code, 0);
    checkOutput("rst_loop", loop_done, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    checkOutput("idle_wait_busy", busy, 0);

    // stop together with play stays in IDLE
    applyStimulus(1, 1);
    @(negedge clk);
    checkIdle("stop_play");

    // First note held in OFFER for 10 cycles, then full note and space
    pushRun(0, 2);
    applyStimulus(1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("offer_valid", tone_if.note_valid, 1);
      checkOutput("offer_code", tone_if.note_code, ROM_CODE[0]);
      checkOutput("offer_gate", tone_if.note_gate, 0);
    end
    @(posedge clk);
    #2 tone_if.note_ready = 1;
    waitQueue(0, 400, "wait_first_run");
    waitGateHigh(50);
    repeat (5) @(negedge clk);
    applyStimulus(0, 1);
    @(negedge clk);
    checkIdle("stop_mid_note");

    // Whole loop plus the first note of the next pass; play while busy ignored
    loop_cnt = 0;
    pushRun(0, LEN + 1);
    applyStimulus(1, 0);
    waitQueue(LEN - 2, 400, "wait_loop_start");
    applyStimulus(1, 0);
    checkOutput("play_busy_ignored", busy, 1);
    waitQueue(0, 4000, "wait_loop_end");
    repeat (3) @(negedge clk);
    checkOutput("loop_count", loop_cnt, 1);
    applyStimulus(0, 1);
    @(negedge clk);
    checkIdle("stop_after_loop");

    // Pause for 20 strobes after the first tick of the first (long) note
    pushRun(0, 2);
    applyStimulus(1, 0);
    waitGateHigh(50);
    begin
      int n = 0;
      while (gate_cnt < TW && n < 100) begin
        @(negedge clk); #1; n++;
      end
      checkOutput("wait_tick1", gate_cnt, TW);
    end
    @(posedge clk);
    #2 pause = 1;
    for (int i = 0; i < 20; i++) begin
      int n2 = 0;
      do begin
        @(negedge clk); n2++;
      end while (!sample_stb && n2 < 10);
      checkOutput("pause_gate", tone_if.note_gate, PAUSE_GATE);
      checkOutput("pause_busy", busy, 1);
    end
    @(posedge clk);
    #2 pause = 0;
    waitQueue(0, 400, "wait_pause_run");
    applyStimulus(0, 1);
    @(negedge clk);
    checkIdle("stop_after_pause");

    // Asynchronous reset in the middle of a note
    pushRun(0, 1);
    applyStimulus(1, 0);
    waitQueue(0, 50, "wait_rst_run");
    waitGateHigh(50);
    repeat (3) @(negedge clk);
    #1 rst = 1;
    #1;
    checkOutput("async_rst_gate", tone_if.note_gate, 0);
    checkOutput("async_rst_busy", busy, 0);
    #1 rst = 0;
    repeat (4) @(negedge clk);
    checkIdle("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
